arbitro_sessao: RTL and testbench

- Sequential session arbiter that shares the two output interfaces (IS1 = LED matrix, IS2 = LED bar) between input stations IE1 and IE2.
- Sits between the user/function validation stage and the output decoders. Grants exclusive, time-bounded ownership of each IS.
- Ranks requesters by user priority ADMIN > TESTER > USER > GUEST. Breaks ties round-robin.
- Supports preemption, timeout and a cool-down gap between sessions.

---
 rtl/pkg_painel.sv | 40 ++++
 rtl/arbitro_is.sv | 149 ++++++++++++++
 rtl/arbitro_sessao.sv | 106 ++++++++++
 tb/tb_arbitro_sessao.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_painel.sv
// Shared definitions for the session arbiter: user codes, owner encoding,
// FSM states and the user-priority helpers.
package pkg_painel;

  localparam logic [2:0] ADMIN  = 3'b100;
  localparam logic [2:0] TESTER = 3'b011;
  localparam logic [2:0] USER   = 3'b010;
  localparam logic [2:0] GUEST  = 3'b001;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IE1  = 2'b01;
  localparam logic [1:0] OWN_IE2  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN1 = 2'b01,
    ST_OWN2 = 2'b10,
    ST_COOL = 2'b11
  } state_t;

  // Relative priority among the four valid codes (GUEST lowest). Four valid
  // levels fill the 2-bit range, so validity is reported by user_ok.
  function automatic logic [1:0] rank(input logic [2:0] user);
    case (user)
      ADMIN:   rank = 2'd3;
      TESTER:  rank = 2'd2;
      USER:    rank = 2'd1;
      default: rank = 2'd0;
    endcase
  endfunction

  // True only for the four recognised user codes.
  function automatic logic user_ok(input logic [2:0] user);
    case (user)
      ADMIN, TESTER, USER, GUEST: user_ok = 1'b1;
      default:                    user_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arbitro_is.sv
// Ownership FSM for one output interface: arbitration between the two
// qualified candidates, hold/cool timing, round-robin tie break, func latch.
module arbitro_is
  import pkg_painel::*;
#(
  parameter int MIN_HOLD    = 8,
  parameter int MAX_HOLD    = 64,
  parameter int COOL_CYCLES = 2,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cand1,
  input  logic [1:0] rank1,
  input  logic [2:0] func1,
  input  logic       stay1,
  input  logic       cand2,
  input  logic [1:0] rank2,
  input  logic [2:0] func2,
  input  logic       stay2,
  output logic       gnt1,
  output logic       gnt2,
  output logic       drop1,
  output logic       drop2,
  output logic [1:0] owner,
  output logic [2:0] func
);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] cool_cnt;
  logic             rr;        // 0 favours IE1 on a tie, 1 favours IE2
  logic [1:0]       own_rank;  // rank of the current owner, latched at grant
  logic             pick2;
  logic             any_cand;
  logic             owner_stay;
  logic             challenge;
  logic             end_sess;
  logic             end_drop;

  // Winner selection in IDLE and end-of-session decision while owned.
  always_comb begin
    pick2      = 1'b0;
    owner_stay = 1'b0;
    challenge  = 1'b0;
    end_sess   = 1'b0;
    end_drop   = 1'b0;
    any_cand   = cand1 | cand2;
    if (cand1 && cand2) begin
      if (rank1 > rank2) begin
        pick2 = 1'b0;
      end else if (rank2 > rank1) begin
        pick2 = 1'b1;
      end else begin
        pick2 = rr;
      end
    end else begin
      pick2 = cand2;
    end
    if (state == ST_OWN1) begin
      owner_stay = stay1;
      challenge  = cand2 && (rank2 > own_rank);
    end else begin
      owner_stay = stay2;
      challenge  = cand1 && (rank1 > own_rank);
    end
    // Voluntary release outranks timeout, which outranks preemption.
    if (!owner_stay) begin
      end_sess = 1'b1;
      end_drop = 1'b0;
    end else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
      end_sess = 1'b1;
      end_drop = 1'b1;
    end else if (challenge && (hold_cnt >= CNT_W'(MIN_HOLD - 1))) begin
      end_sess = 1'b1;
      end_drop = 1'b1;
    end else begin
      end_sess = 1'b0;
      end_drop = 1'b0;
    end
  end

  // Session FSM with registered grant, drop, owner and func outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= {CNT_W{1'b0}};
      cool_cnt <= {CNT_W{1'b0}};
      rr       <= 1'b0;
      own_rank <= 2'b00;
      gnt1     <= 1'b0;
      gnt2     <= 1'b0;
      drop1    <= 1'b0;
      drop2    <= 1'b0;
      owner    <= OWN_NONE;
      func     <= 3'b000;
    end else begin
      drop1 <= 1'b0;
      drop2 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_cand) begin
            state    <= pick2 ? ST_OWN2 : ST_OWN1;
            gnt1     <= ~pick2;
            gnt2     <= pick2;
            owner    <= pick2 ? OWN_IE2 : OWN_IE1;
            func     <= pick2 ? func2 : func1;
            own_rank <= pick2 ? rank2 : rank1;
            hold_cnt <= {CNT_W{1'b0}};
            rr       <= ~pick2;  // next tie goes to the loser
          end
        end
        ST_OWN1, ST_OWN2: begin
          if (end_sess) begin
            state    <= ST_COOL;
            gnt1     <= 1'b0;
            gnt2     <= 1'b0;
            owner    <= OWN_NONE;
            func     <= 3'b000;
            hold_cnt <= {CNT_W{1'b0}};
            cool_cnt <= {CNT_W{1'b0}};
            drop1    <= end_drop & (state == ST_OWN1);
            drop2    <= end_drop & (state == ST_OWN2);
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        ST_COOL: begin
          if (cool_cnt == CNT_W'(COOL_CYCLES - 1)) begin
            state    <= ST_IDLE;
            cool_cnt <= {CNT_W{1'b0}};
          end else begin
            cool_cnt <= cool_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          gnt1     <= 1'b0;
          gnt2     <= 1'b0;
          owner    <= OWN_NONE;
          func     <= 3'b000;
          hold_cnt <= {CNT_W{1'b0}};
          cool_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/arbitro_sessao.sv
// Session arbiter top: per-station armed flags, candidate qualification for
// each output interface and merging of the per-interface grant/drop signals.
module arbitro_sessao
  import pkg_painel::*;
#(
  parameter int MIN_HOLD    = 8,
  parameter int MAX_HOLD    = 64,
  parameter int COOL_CYCLES = 2,
  parameter int CNT_W       = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ie1_req,
  input  logic [2:0] ie1_user,
  input  logic [2:0] ie1_func,
  input  logic       ie1_is,
  input  logic       ie2_req,
  input  logic [2:0] ie2_user,
  input  logic [2:0] ie2_func,
  input  logic       ie2_is,
  output logic       ie1_gnt,
  output logic       ie2_gnt,
  output logic       ie1_drop,
  output logic       ie2_drop,
  output logic [1:0] is1_owner,
  output logic [1:0] is2_owner,
  output logic [2:0] is1_func,
  output logic [2:0] is2_func
);

  logic            armed1;
  logic            armed2;
  logic [1:0]      g1;
  logic [1:0]      g2;
  logic [1:0]      d1;
  logic [1:0]      d2;
  logic [1:0][1:0] own;
  logic [1:0][2:0] fn;

  // Armed flags: a dropped station must release its request before it may
  // compete again, so a timed-out owner cannot immediately re-grab the IS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed1 <= 1'b1;
      armed2 <= 1'b1;
    end else begin
      if (ie1_drop) begin
        armed1 <= 1'b0;
      end else if (!ie1_req) begin
        armed1 <= 1'b1;
      end
      if (ie2_drop) begin
        armed2 <= 1'b0;
      end else if (!ie2_req) begin
        armed2 <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_is
    localparam logic IDX = (k == 1) ? 1'b1 : 1'b0;
    logic stay1;
    logic stay2;
    logic cand1;
    logic cand2;

    assign stay1 = ie1_req && (ie1_is == IDX);
    assign stay2 = ie2_req && (ie2_is == IDX);
    assign cand1 = stay1 && user_ok(ie1_user) && armed1;
    assign cand2 = stay2 && user_ok(ie2_user) && armed2;

    arbitro_is #(
      .MIN_HOLD   (MIN_HOLD),
      .MAX_HOLD   (MAX_HOLD),
      .COOL_CYCLES(COOL_CYCLES),
      .CNT_W      (CNT_W)
    ) u_is (
      .clk  (clk),
      .reset(reset),
      .cand1(cand1),
      .rank1(rank(ie1_user)),
      .func1(ie1_func),
      .stay1(stay1),
      .cand2(cand2),
      .rank2(rank(ie2_user)),
      .func2(ie2_func),
      .stay2(stay2),
      .gnt1 (g1[k]),
      .gnt2 (g2[k]),
      .drop1(d1[k]),
      .drop2(d2[k]),
      .owner(own[k]),
      .func (fn[k])
    );
  end

  assign ie1_gnt   = g1[0] | g1[1];
  assign ie2_gnt   = g2[0] | g2[1];
  assign ie1_drop  = d1[0] | d1[1];
  assign ie2_drop  = d2[0] | d2[1];
  assign is1_owner = own[0];
  assign is2_owner = own[1];
  assign is1_func  = fn[0];
  assign is2_func  = fn[1];

endmodule

// File: tb/tb_arbitro_sessao.sv
// Scoreboard bench for arbitro_sessao: the stimulus thread schedules expected
// output snapshots per cycle; the monitor compares them on the falling edge.
module tb_arbitro_sessao;
  import pkg_painel::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ie1_req = 1'b0, ie2_req = 1'b0;
  logic [2:0] ie1_user = 3'b000, ie2_user = 3'b000;
  logic [2:0] ie1_func = 3'b000, ie2_func = 3'b000;
  logic       ie1_is = 1'b0, ie2_is = 1'b0;
  logic       ie1_gnt, ie2_gnt, ie1_drop, ie2_drop;
  logic [1:0] is1_owner, is2_owner;
  logic [2:0] is1_func, is2_func;

  arbitro_sessao dut (
    .clk(clk), .reset(reset),
    .ie1_req(ie1_req), .ie1_user(ie1_user), .ie1_func(ie1_func), .ie1_is(ie1_is),
    .ie2_req(ie2_req), .ie2_user(ie2_user), .ie2_func(ie2_func), .ie2_is(ie2_is),
    .ie1_gnt(ie1_gnt), .ie2_gnt(ie2_gnt), .ie1_drop(ie1_drop), .ie2_drop(ie2_drop),
    .is1_owner(is1_owner), .is2_owner(is2_owner),
    .is1_func(is1_func), .is2_func(is2_func)
  );

  always #5 clk = ~clk;

  // Observed vector: {gnt1, gnt2, drop1, drop2, is1_owner, is2_owner, is1_func, is2_func}
  logic [13:0] obs;
  assign obs = {ie1_gnt, ie2_gnt, ie1_drop, ie2_drop, is1_owner, is2_owner, is1_func, is2_func};
  localparam logic [13:0] ZERO = 14'd0;

  typedef struct {
    int          at;
    string       nm;
    logic [13:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   last_at = 0;
  int   total = 0;
  int   bad = 0;

  function automatic logic [13:0] mk(input logic g1, input logic g2, input logic d1,
                                     input logic d2, input logic [1:0] o1, input logic [1:0] o2,
                                     input logic [2:0] f1, input logic [2:0] f2);
    return {g1, g2, d1, d2, o1, o2, f1, f2};
  endfunction

  task automatic expect_at(input int at, input string nm, input logic [13:0] v);
    exp_t e;
    e.at = at;
    e.nm = nm;
    e.v  = v;
    sb.push_back(e);
    if (at > last_at) last_at = at;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set1(input logic r, input logic [2:0] u, input logic [2:0] f, input logic s);
    ie1_req = r; ie1_user = u; ie1_func = f; ie1_is = s;
  endtask

  task automatic set2(input logic r, input logic [2:0] u, input logic [2:0] f, input logic s);
    ie2_req = r; ie2_user = u; ie2_func = f; ie2_is = s;
  endtask

  // Cycle counter: number of rising edges seen so far.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: compare every expectation due in the current cycle.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < sb.size(); ) begin
      if (sb[i].at == cyc) begin
        total = total + 1;
        if (obs !== sb[i].v) begin
          bad = bad + 1;
          $display("FAIL %s cycle %0d: got %b want %b", sb[i].nm, cyc, obs, sb[i].v);
        end
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        total = total + 1;
        bad = bad + 1;
        $display("FAIL %s: cycle %0d passed unchecked (now %0d)", sb[i].nm, sb[i].at, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    int c;
    int g;
    // Reset state
    wait_cyc(2);
    expect_at(cyc, "reset_state", ZERO);
    wait_cyc(3);
    reset = 1'b0;

    // T1: single GUEST on IS1, func latched at grant only
    wait_cyc(5);
    c = cyc;
    set1(1'b1, GUEST, 3'b101, 1'b0);
    expect_at(c + 1, "t1_grant", mk(1'b1, 1'b0, 1'b0, 1'b0, OWN_IE1, OWN_NONE, 3'b101, 3'b000));
    wait_cyc(c + 1);
    ie1_func = 3'b110;
    expect_at(c + 2, "t1_func_hold", mk(1'b1, 1'b0, 1'b0, 1'b0, OWN_IE1, OWN_NONE, 3'b101, 3'b000));
    wait_cyc(c + 2);
    ie1_req = 1'b0;
    expect_at(c + 3, "t1_release", ZERO);
    wait_cyc(c + 8);

    // T2: USER vs ADMIN on IS1; loser granted after release + cool
    c = cyc;
    set1(1'b1, USER, 3'b001, 1'b0);
    set2(1'b1, ADMIN, 3'b010, 1'b0);
    expect_at(c + 1, "t2_admin_wins", mk(1'b0, 1'b1, 1'b0, 1'b0, OWN_IE2, OWN_NONE, 3'b010, 3'b000));
    wait_cyc(c + 3);
    c = cyc;
    ie2_req = 1'b0;
    expect_at(c + 1, "t2_cool_a", ZERO);
    expect_at(c + 2, "t2_cool_b", ZERO);
    expect_at(c + 3, "t2_idle", ZERO);
    expect_at(c + 4, "t2_user_granted", mk(1'b1, 1'b0, 1'b0, 1'b0, OWN_IE1, OWN_NONE, 3'b001, 3'b000));
    wait_cyc(c + 4);
    ie1_req = 1'b0;
    wait_cyc(c + 10);

    // T3: equal-rank TESTERs on IS2, 3-cycle sessions, alternating grants
    c = cyc;
    set1(1'b1, TESTER, 3'b011, 1'b1);
    set2(1'b1, TESTER, 3'b100, 1'b1);
    g = c + 1;
    for (int r = 0; r < 4; r++) begin
      if (r % 2 == 0)
        expect_at(g, "t3_rr_ie1", mk(1'b1, 1'b0, 1'b0, 1'b0, OWN_NONE, OWN_IE1, 3'b000, 3'b011));
      else
        expect_at(g, "t3_rr_ie2", mk(1'b0, 1'b1, 1'b0, 1'b0, OWN_NONE, OWN_IE2, 3'b000, 3'b100));
      expect_at(g + 4, "t3_cool", ZERO);
      wait_cyc(g + 2);
      if (r % 2 == 0) ie1_req = 1'b0; else ie2_req = 1'b0;
      wait_cyc(g + 3);
      if (r % 2 == 0) ie1_req = 1'b1; else ie2_req = 1'b1;
      g = g + 6;
    end
    ie1_req = 1'b0;
    ie2_req = 1'b0;
    wait_cyc(cyc + 6);

    // T4: timeout after 64 held cycles, no regrant until req toggles
    c = cyc;
    set1(1'b1, USER, 3'b111, 1'b0);
    expect_at(c + 1,   "t4_grant",     mk(1'b1, 1'b0, 1'b0, 1'b0, OWN_IE1, OWN_NONE, 3'b111, 3'b000));
    expect_at(c + 64,  "t4_last_hold", mk(1'b1, 1'b0, 1'b0, 1'b0, OWN_IE1, OWN_NONE, 3'b111, 3'b000));
    expect_at(c + 65,  "t4_drop",      mk(1'b0, 1'b0, 1'b1, 1'b0, OWN_NONE, OWN_NONE, 3'b000, 3'b000));
    expect_at(c + 66,  "t4_cool",      ZERO);
    expect_at(c + 70,  "t4_no_regrant_a", ZERO);
    expect_at(c + 100, "t4_no_regrant_b", ZERO);
    wait_cyc(c + 100);
    ie1_req = 1'b0;
    wait_cyc(c + 101);
    ie1_req = 1'b1;
    expect_at(c + 102, "t4_regrant", mk(1'b1, 1'b0, 1'b0, 1'b0, OWN_IE1, OWN_NONE, 3'b111, 3'b000));
    wait_cyc(c + 102);
    ie1_req = 1'b0;
    wait_cyc(c + 108);

    // T5: ADMIN preempts GUEST only once hold_cnt reaches MIN_HOLD-1
    c = cyc;
    set1(1'b1, GUEST, 3'b001, 1'b0);
    expect_at(c + 1, "t5_guest_grant", mk(1'b1, 1'b0, 1'b0, 1'b0, OWN_IE1, OWN_NONE, 3'b001, 3'b000));
    wait_cyc(c + 4);
    set2(1'b1, ADMIN, 3'b110, 1'b0);
    expect_at(c + 5,  "t5_no_preempt_early", mk(1'b1, 1'b0, 1'b0, 1'b0, OWN_IE1, OWN_NONE, 3'b001, 3'b000));
    expect_at(c + 8,  "t5_still_guest",      mk(1'b1, 1'b0, 1'b0, 1'b0, OWN_IE1, OWN_NONE, 3'b001, 3'b000));
    expect_at(c + 9,  "t5_preempt_drop",     mk(1'b0, 1'b0, 1'b1, 1'b0, OWN_NONE, OWN_NONE, 3'b000, 3'b000));
    expect_at(c + 10, "t5_cool",             ZERO);
    expect_at(c + 12, "t5_admin_owner",      mk(1'b0, 1'b1, 1'b0, 1'b0, OWN_IE2, OWN_NONE, 3'b110, 3'b000));
    wait_cyc(c + 12);
    ie1_req = 1'b0;
    ie2_req = 1'b0;
    wait_cyc(c + 18);

    // T6: concurrent owners, asynchronous reset mid-session, then resume
    c = cyc;
    set1(1'b1, USER, 3'b010, 1'b0);
    set2(1'b1, TESTER, 3'b101, 1'b1);
    expect_at(c + 1, "t6_both_granted", mk(1'b1, 1'b1, 1'b0, 1'b0, OWN_IE1, OWN_IE2, 3'b010, 3'b101));
    wait_cyc(c + 3);
    reset = 1'b1;
    expect_at(c + 3, "t6_async_reset", ZERO);
    expect_at(c + 4, "t6_reset_held", ZERO);
    wait_cyc(c + 4);
    reset = 1'b0;
    expect_at(c + 5, "t6_resume", mk(1'b1, 1'b1, 1'b0, 1'b0, OWN_IE1, OWN_IE2, 3'b010, 3'b101));
    wait_cyc(c + 6);
    ie1_req = 1'b0;
    ie2_req = 1'b0;

    wait_cyc(last_at + 3);
    while (sb.size() > 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL %s: expectation for cycle %0d left in scoreboard", sb[0].nm, sb[0].at);
      void'(sb.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
